fifo_uart_tx: RTL and testbench

- Consumer end of the CPU output FIFO: pops words the CPU wrote to the FIFO address and serializes them onto a UART TX line.
- Each word is sent as DATA_WIDTH/8 frames, least-significant byte first.
- Frame format is 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- Sits between the FIFO read port and the board TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_byte.sv | 64 ++++++
 rtl/fifo_uart_tx.sv | 70 +++++++
 tb/tb_fifo_uart_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and 8N1 framing constants for the FIFO UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} uart_state_e;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam int UART_BITS_PER_BYTE = 8;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; owns the baud counter and bit index, and can chain straight into the next start bit.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       tx_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d;
  logic wrap;
  assign wrap = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign done_o = state_q == STOP && wrap;
  assign tx_o = tx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = START;
        tx_d = UART_START_BIT;
      end
      START: if (wrap) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = data_i[0];
      end
      DATA: if (wrap) begin
        state_d = bit_q == 3'(UART_BITS_PER_BYTE - 1) ? STOP : DATA;
        bit_d = bit_q + 1'b1;
        tx_d = bit_q == 3'(UART_BITS_PER_BYTE - 1) ? UART_STOP_BIT : data_i[bit_q + 3'd1];
      end
      STOP: if (wrap) begin
        // a pending start skips IDLE so bytes of one word run back-to-back
        state_d = start_i ? START : IDLE;
        tx_d = start_i ? UART_START_BIT : UART_STOP_BIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= UART_STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a registered-read FIFO and sends them LSB byte first as 8N1 UART frames.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enabled,
  output logic                  tx,
  output logic                  busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  // START here covers the whole serializer run; its START/DATA/STOP phases live in uart_tx_byte
  uart_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0] byte_q, byte_d;
  logic done, start, last;
  logic [7:0] cur_byte;
  assign last = byte_q == BW'(BYTES - 1);
  assign start = state_q == LATCH || (state_q == START && done && !last);
  assign cur_byte = word_q[8*int'(byte_q) +: 8];
  assign fifo_read_enabled = state_q == POP;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    byte_d = byte_q;
    case (state_q)
      IDLE: state_d = fifo_empty ? IDLE : POP;
      POP: state_d = LATCH;
      LATCH: begin
        state_d = START;
        word_d = fifo_data_out;
        byte_d = '0;
      end
      START: if (done) begin
        state_d = last ? IDLE : START;
        byte_d = last ? byte_q : byte_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= '0;
      byte_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      byte_q <= byte_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk(clk),
    .rst(rst),
    .data_i(cur_byte),
    .start_i(start),
    .done_o(done),
    .tx_o(tx)
  );
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model feeding the transmitter, line decoder checking frames against a byte scoreboard.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW = 32;
  typedef struct {
    logic [31:0] word;
    logic [7:0] b0, b1, b2, b3;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic fifo_empty, fifo_read_enabled, tx, busy;
  logic fe_ovr = 1'b1, fe_val = 1'b0;
  logic [DW-1:0] mem[16];
  int wr = 0, rd = 0, pops = 0, bad_pops = 0;
  int checks = 0, failures = 0, frames = 0;
  logic [7:0] exp_q[$];
  logic tr_tx[0:339], tr_fre[0:339], tr_busy[0:339];
  vec_t tbl[3];
  assign fifo_empty = fe_ovr ? fe_val : (wr == rd);
  always #5 clk = ~clk;
  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty),
    .fifo_read_enabled(fifo_read_enabled),
    .tx(tx),
    .busy(busy)
  );
  always @(posedge clk) begin
    if (fifo_read_enabled) begin
      pops <= pops + 1;
      if (wr == rd) bad_pops <= bad_pops + 1;
      else begin
        fifo_data_out <= mem[rd % 16];
        rd <= rd + 1;
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_word(input logic [31:0] w);
    mem[wr % 16] = w;
    wr++;
  endtask
  task automatic trace(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr_tx[i] = tx;
      tr_fre[i] = fifo_read_enabled;
      tr_busy[i] = busy;
    end
  endtask
  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    repeat (3) @(negedge clk);
    while ((busy || exp_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, k < budget, 1);
  endtask
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int j = 0; j < 40; j++) f[j] = (j / 4 == 0) ? 1'b0 : (j / 4 == 9) ? 1'b1 : b[j/4-1];
    return f;
  endfunction
  // line decoder: every bit must hold for all CPB samples; frames hit by reset are dropped
  initial forever begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      logic [7:0] b;
      logic ok, ab;
      ok = 1'b1;
      ab = 1'b0;
      b = '0;
      for (int j = 1; j < CPB; j++) begin
        @(negedge clk);
        if (rst) ab = 1'b1;
        if (tx !== 1'b0) ok = 1'b0;
      end
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < CPB; j++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          if (j == 0) b[i] = tx;
          else if (tx !== b[i]) ok = 1'b0;
        end
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (rst) ab = 1'b1;
        if (tx !== 1'b1) ok = 1'b0;
      end
      if (!ab) begin
        frames++;
        chk("frame_timing", ok, 1);
        if (exp_q.size() == 0) chk("unexpected_frame", b, 0);
        else chk("frame_byte", b, exp_q.pop_front());
      end
    end
  end
  initial begin
    int p0, f0, run, n;
    logic [39:0] got;
    tbl[0] = '{32'h44434241, 8'h41, 8'h42, 8'h43, 8'h44};
    tbl[1] = '{32'h12A5005A, 8'h5A, 8'h00, 8'hA5, 8'h12};
    tbl[2] = '{32'h80FF7F01, 8'h01, 8'h7F, 8'hFF, 8'h80};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pop", fifo_read_enabled, 0);
    end
    chk("rst_no_pop", pops, 0);
    fe_val = 1'b1;
    rst = 1'b0;
    fe_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_idle_rst_tx", tx, 1);
    chk("mid_idle_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    // single word: detailed cycle timing
    p0 = pops;
    push_word(32'h44434241);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    trace(170);
    chk("pop_at_T1", tr_fre[1], 1);
    n = 0;
    for (int i = 1; i <= 170; i++) n += int'(tr_fre[i]);
    chk("single_pop_count", n, 1);
    chk("tx_high_T2", tr_tx[2], 1);
    chk("tx_low_T3", tr_tx[3], 0);
    for (int j = 0; j < 40; j++) got[j] = tr_tx[3+j];
    chk("frame41_bits", got, frame_bits(8'h41));
    chk("no_gap_before_42", tr_tx[43], 0);
    n = 0;
    for (int i = 1; i <= 170; i++) n += int'(tr_busy[i]);
    chk("busy_len", n, 162);
    chk("busy_fall_T163", {tr_busy[162], tr_busy[163]}, 2'b10);
    chk("single_sb_empty", exp_q.size(), 0);
    // back-to-back words
    p0 = pops;
    f0 = frames;
    push_word(32'h00000000);
    push_word(32'hFFFFFFFF);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'hFF);
    trace(330);
    run = 0;
    for (int i = 165; i > 0 && tr_tx[i]; i--) run++;
    chk("inter_word_gap", run - CPB, 3);
    chk("word2_start", tr_tx[166], 0);
    wait_idle(400, "b2b_timeout");
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_frames", frames - f0, 8);
    // table-driven words
    for (int v = 0; v < 3; v++) begin
      p0 = pops;
      push_word(tbl[v].word);
      exp_q.push_back(tbl[v].b0);
      exp_q.push_back(tbl[v].b1);
      exp_q.push_back(tbl[v].b2);
      exp_q.push_back(tbl[v].b3);
      wait_idle(400, "tbl_timeout");
      chk("tbl_pops", pops - p0, 1);
    end
    // fifo_empty toggling while busy
    p0 = pops;
    push_word(32'h3C5AA5C3);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      fe_ovr = 1'b1;
      fe_val = i[0];
      repeat (3) @(negedge clk);
    end
    fe_ovr = 1'b0;
    wait_idle(400, "toggle_timeout");
    repeat (10) @(negedge clk);
    chk("toggle_pops", pops - p0, 1);
    // reset during a data bit of the third byte (all zeros, line low)
    p0 = pops;
    push_word(32'hCC00BBAA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    repeat (95) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    trace(100);
    n = 0;
    for (int i = 1; i <= 100; i++) n += int'(tr_busy[i]) + int'(tr_fre[i]) + int'(!tr_tx[i]);
    chk("post_rst_quiet", n, 0);
    chk("rst_pops", pops - p0, 1);
    chk("rst_sb_empty", exp_q.size(), 0);
    chk("no_pop_when_empty", bad_pops, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
